// File: rtl/cabac_coe_pkg.sv
// Shared constants, types and helpers for the CABAC coefficient-group fetch path.
// COEFF_WIDTH normally comes from enc_defines; a 16-bit fallback keeps this slice self-contained.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

package cabac_coe_pkg;

    localparam int COEFF_WIDTH = `COEFF_WIDTH;
    localparam int CG_WIDTH    = 16 * COEFF_WIDTH;

    localparam logic [1:0] TU_SIZE_4X4   = 2'd0;
    localparam logic [1:0] TU_SIZE_8X8   = 2'd1;
    localparam logic [1:0] TU_SIZE_16X16 = 2'd2;
    localparam logic [1:0] TU_SIZE_32X32 = 2'd3;

    localparam logic [1:0] COMP_Y = 2'd2;
    localparam logic [1:0] COMP_U = 2'd1;
    localparam logic [1:0] COMP_V = 2'd0;

    // Raster index feeding each up-right diagonal scan position inside a 4x4 CG.
    localparam logic [3:0] DIAG_SCAN [16] = '{
        4'd0, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2, 4'd12, 4'd9,
        4'd6, 4'd3, 4'd13, 4'd10, 4'd7, 4'd14, 4'd11, 4'd15
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } cg_state_t;

    function automatic logic [2:0] grid_max(input logic [1:0] tu_size);
        case (tu_size)
            TU_SIZE_4X4:   return 3'd0;
            TU_SIZE_8X8:   return 3'd1;
            TU_SIZE_16X16: return 3'd3;
            default:       return 3'd7;
        endcase
    endfunction

    function automatic logic [5:0] cg_last_idx(input logic [1:0] tu_size);
        case (tu_size)
            TU_SIZE_4X4:   return 6'd0;
            TU_SIZE_8X8:   return 6'd3;
            TU_SIZE_16X16: return 6'd15;
            default:       return 6'd63;
        endcase
    endfunction

    // Z-order placement of a CG inside the TU: x on even bits, y on odd bits.
    function automatic logic [5:0] cg_interleave(input logic [2:0] x, input logic [2:0] y);
        return {y[2], x[2], y[1], x[1], y[0], x[0]};
    endfunction

endpackage

// File: rtl/cabac_diag4x4_scan.sv
// Combinational reorder of a raster 4x4 CG into diagonal scan order, plus its significance map.

module cabac_diag4x4_scan
    import cabac_coe_pkg::*;
(
    input  logic [CG_WIDTH-1:0] raster_dat,
    output logic [CG_WIDTH-1:0] scan_dat,
    output logic [15:0]         scan_sig
);

    for (genvar n = 0; n < 16; n++) begin : g_slot
        localparam int K = int'(DIAG_SCAN[n]);
        assign scan_dat[(16-n)*COEFF_WIDTH-1 -: COEFF_WIDTH] =
            raster_dat[(16-K)*COEFF_WIDTH-1 -: COEFF_WIDTH];
        assign scan_sig[n] = |raster_dat[(16-K)*COEFF_WIDTH-1 -: COEFF_WIDTH];
    end

endmodule

// File: rtl/cabac_cg_fetch.sv
// Walks a TU's CGs in up-right diagonal order, reads them, reorders to scan order and queues them.
// Optional CABAC_CG_ZERO_SKIP_EN drops all-zero CGs other than the first and the last.

module cabac_cg_fetch
    import cabac_coe_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [1:0]          tu_size_i,
    input  logic [1:0]          tu_sel_i,
    input  logic [8:0]          tu_base_i,
    output logic                coe_rd_ena_o,
    output logic [8:0]          coe_rd_addr_o,
    output logic [1:0]          coe_rd_sel_o,
    input  logic [CG_WIDTH-1:0] coe_rd_dat_i,
    output logic                cg_valid_o,
    input  logic                cg_ready_i,
    output logic [CG_WIDTH-1:0] cg_dat_o,
    output logic [15:0]         cg_sig_o,
    output logic [5:0]          cg_idx_o,
    output logic                cg_last_o,
    output logic                busy_o,
    output logic                done_o
);

    cg_state_t     state;
    logic [2:0]    cur_x;
    logic [2:0]    cur_y;
    logic [2:0]    grid_n;
    logic [5:0]    last_idx;
    logic [5:0]    issue_idx;
    logic [8:0]    base;

    logic [3:0]    diag_nxt;
    logic [2:0]    x_nxt;
    logic [2:0]    y_nxt;

    logic          rd_issue;
    logic          dat_pend;
    logic [5:0]    pend_idx;
    logic          pend_last;

    logic [CG_WIDTH-1:0] scan_dat;
    logic [15:0]         scan_sig;
    logic                keep;

    logic [CG_WIDTH-1:0] fifo_dat  [2];
    logic [15:0]         fifo_sig  [2];
    logic [5:0]          fifo_idx  [2];
    logic                fifo_last [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;
    logic                fifo_push;
    logic                fifo_pop;

    // Next CG along the up-right diagonal walk; wraps to the next anti-diagonal at the grid edge.
    always_comb begin
        diag_nxt = {1'b0, cur_x} + {1'b0, cur_y} + 4'd1;
        x_nxt    = cur_x + 3'd1;
        y_nxt    = cur_y - 3'd1;
        if (cur_y == 3'd0 || cur_x == grid_n) begin
            y_nxt = (diag_nxt > {1'b0, grid_n}) ? grid_n : diag_nxt[2:0];
            x_nxt = 3'(diag_nxt - {1'b0, y_nxt});
        end
    end

    // A read's data must always find a FIFO slot, so a slot freed by this cycle's pop counts as free.
    assign fifo_pop     = cg_valid_o && cg_ready_i;
    assign rd_issue     = (state == RUN) &&
                          (({1'b0, occ} + {2'b0, dat_pend}) < (3'd2 + {2'b0, fifo_pop}));
    assign coe_rd_ena_o = rd_issue;
    assign busy_o       = (state != IDLE);

    cabac_diag4x4_scan u_scan (
        .raster_dat (coe_rd_dat_i),
        .scan_dat   (scan_dat),
        .scan_sig   (scan_sig)
    );

`ifdef CABAC_CG_ZERO_SKIP_EN
    assign keep = (scan_sig != 16'd0) || (pend_idx == 6'd0) || pend_last;
`else
    assign keep = 1'b1;
`endif

    assign fifo_push = dat_pend && keep;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_x         <= 3'd0;
            cur_y         <= 3'd0;
            grid_n        <= 3'd0;
            last_idx      <= 6'd0;
            issue_idx     <= 6'd0;
            base          <= 9'd0;
            coe_rd_addr_o <= 9'd0;
            coe_rd_sel_o  <= COMP_Y;
            dat_pend      <= 1'b0;
            pend_idx      <= 6'd0;
            pend_last     <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            dat_pend  <= rd_issue;
            pend_idx  <= issue_idx;
            pend_last <= (issue_idx == last_idx);
            done_o    <= fifo_pop && cg_last_o;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state         <= RUN;
                        grid_n        <= grid_max(tu_size_i);
                        last_idx      <= cg_last_idx(tu_size_i);
                        base          <= tu_base_i;
                        coe_rd_addr_o <= tu_base_i;
                        coe_rd_sel_o  <= tu_sel_i;
                        cur_x         <= 3'd0;
                        cur_y         <= 3'd0;
                        issue_idx     <= 6'd0;
                    end
                end
                RUN: begin
                    if (rd_issue) begin
                        cur_x         <= x_nxt;
                        cur_y         <= y_nxt;
                        issue_idx     <= issue_idx + 6'd1;
                        coe_rd_addr_o <= base | {3'b000, cg_interleave(x_nxt, y_nxt)};
                        if (issue_idx == last_idx) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && cg_last_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO bookkeeping; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_dat[wr_ptr]  <= scan_dat;
            fifo_sig[wr_ptr]  <= scan_sig;
            fifo_idx[wr_ptr]  <= pend_idx;
            fifo_last[wr_ptr] <= pend_last;
        end
    end

    assign cg_valid_o = (occ != 2'd0);
    assign cg_dat_o   = cg_valid_o ? fifo_dat[rd_ptr]  : '0;
    assign cg_sig_o   = cg_valid_o ? fifo_sig[rd_ptr]  : 16'd0;
    assign cg_idx_o   = cg_valid_o ? fifo_idx[rd_ptr]  : 6'd0;
    assign cg_last_o  = cg_valid_o ? fifo_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_cabac_cg_fetch.sv
// Directed TU runs over random coefficient data, checked against a diagonal-walk reference model.
// Honours CABAC_CG_ZERO_SKIP_EN when deciding which CGs must be presented.

module tb_cabac_cg_fetch;
    import cabac_coe_pkg::*;

    localparam int DW = CG_WIDTH;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [15:0]   sig;
        logic [5:0]    idx;
        logic          last;
    } cg_rec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [1:0]    tu_size_i;
    logic [1:0]    tu_sel_i;
    logic [8:0]    tu_base_i;
    logic          coe_rd_ena_o;
    logic [8:0]    coe_rd_addr_o;
    logic [1:0]    coe_rd_sel_o;
    logic [DW-1:0] coe_rd_dat_i;
    logic          cg_valid_o;
    logic          cg_ready_i;
    logic [DW-1:0] cg_dat_o;
    logic [15:0]   cg_sig_o;
    logic [5:0]    cg_idx_o;
    logic          cg_last_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [512];
    logic [8:0]    exp_addr [$];
    cg_rec_t       exp_cg   [$];
    logic [8:0]    got_addr [$];
    logic [1:0]    got_sel  [$];
    cg_rec_t       got_cg   [$];
    int            first_rd_cyc;
    int            first_vld_cyc;
    int            done_cyc;

    always #5 clk = ~clk;

    cabac_cg_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .tu_size_i     (tu_size_i),
        .tu_sel_i      (tu_sel_i),
        .tu_base_i     (tu_base_i),
        .coe_rd_ena_o  (coe_rd_ena_o),
        .coe_rd_addr_o (coe_rd_addr_o),
        .coe_rd_sel_o  (coe_rd_sel_o),
        .coe_rd_dat_i  (coe_rd_dat_i),
        .cg_valid_o    (cg_valid_o),
        .cg_ready_i    (cg_ready_i),
        .cg_dat_o      (cg_dat_o),
        .cg_sig_o      (cg_sig_o),
        .cg_idx_o      (cg_idx_o),
        .cg_last_o     (cg_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_cg();
        logic [DW-1:0] v;
        for (int b = 0; b < DW; b++) v[b] = 1'($urandom);
        return v;
    endfunction

    function automatic logic [8:0] model_addr(input logic [8:0] base, input int x, input int y);
        logic [8:0] a;
        a = base;
        for (int i = 0; i < 3; i++) begin
            if (((x >> i) & 1) != 0) a[2*i]   = 1'b1;
            if (((y >> i) & 1) != 0) a[2*i+1] = 1'b1;
        end
        return a;
    endfunction

    // Scan position n takes the n-th coefficient met walking anti-diagonals from bottom-left up-right.
    function automatic cg_rec_t model_cg(input logic [DW-1:0] raster, input int idx, input bit last);
        cg_rec_t r;
        int n;
        n = 0;
        r.dat = '0;
        r.sig = '0;
        for (int d = 0; d <= 6; d++) begin
            for (int y = (d < 4 ? d : 3); y >= 0 && d - y <= 3; y--) begin
                int k;
                k = y * 4 + (d - y);
                r.dat[(16-n)*COEFF_WIDTH-1 -: COEFF_WIDTH] = raster[(16-k)*COEFF_WIDTH-1 -: COEFF_WIDTH];
                r.sig[n] = (raster[(16-k)*COEFF_WIDTH-1 -: COEFF_WIDTH] != '0);
                n++;
            end
        end
        r.idx  = 6'(idx);
        r.last = last;
        return r;
    endfunction

    task automatic build_expected(input logic [1:0] size, input logic [8:0] base);
        int n;
        int pos;
        n   = 1 << size;
        pos = 0;
        exp_addr.delete();
        exp_cg.delete();
        for (int d = 0; d <= 2 * n - 2; d++) begin
            for (int y = (d < n ? d : n - 1); y >= 0 && d - y < n; y--) begin
                logic [8:0] a;
                cg_rec_t    r;
                bit         keep;
                a = model_addr(base, d - y, y);
                r = model_cg(mem[a], pos, pos == n * n - 1);
                exp_addr.push_back(a);
`ifdef CABAC_CG_ZERO_SKIP_EN
                keep = (r.sig != 16'd0) || pos == 0 || r.last;
`else
                keep = 1'b1;
`endif
                if (keep) exp_cg.push_back(r);
                pos++;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_rd_ena"},  512'(coe_rd_ena_o),  512'(0));
        check_output({tag, "_rd_addr"}, 512'(coe_rd_addr_o), 512'(0));
        check_output({tag, "_rd_sel"},  512'(coe_rd_sel_o),  512'(COMP_Y));
        check_output({tag, "_valid"},   512'(cg_valid_o),    512'(0));
        check_output({tag, "_dat"},     512'(cg_dat_o),      512'(0));
        check_output({tag, "_sig"},     512'(cg_sig_o),      512'(0));
        check_output({tag, "_idx"},     512'(cg_idx_o),      512'(0));
        check_output({tag, "_last"},    512'(cg_last_o),     512'(0));
        check_output({tag, "_busy"},    512'(busy_o),        512'(0));
        check_output({tag, "_done"},    512'(done_o),        512'(0));
    endtask

    // Drives one TU: start in cycle 0, serves reads with one cycle of latency, logs reads and handshakes.
    task automatic run_tu(input string tag, input logic [1:0] size, input logic [1:0] sel,
                          input logic [8:0] base, input bit toggle_ready,
                          input int reset_after, input int busy_start_cyc);
        logic       prev_ena;
        logic [8:0] prev_addr;
        bit         prev_stall;
        cg_rec_t    prev_out;
        cg_rec_t    cur_out;
        bit         fin;
        int         cyc;
        prev_ena   = 1'b0;
        prev_addr  = '0;
        prev_stall = 1'b0;
        prev_out   = '0;
        fin        = 1'b0;
        cyc        = 0;
        got_addr.delete();
        got_sel.delete();
        got_cg.delete();
        first_rd_cyc  = -1;
        first_vld_cyc = -1;
        done_cyc      = -1;
        @(posedge clk);
        #1;
        start_i      = 1'b1;
        tu_size_i    = size;
        tu_sel_i     = sel;
        tu_base_i    = base;
        cg_ready_i   = 1'b1;
        coe_rd_dat_i = rand_cg();
        while (!fin && cyc < 600) begin
            #3;
            cur_out = {cg_dat_o, cg_sig_o, cg_idx_o, cg_last_o};
            if (prev_stall) begin
                check_output({tag, "_stall_valid"}, 512'(cg_valid_o), 512'(1));
                check_output({tag, "_stall_hold"},  512'(cur_out),    512'(prev_out));
            end
            if (cyc == busy_start_cyc) check_output({tag, "_busy_at_restart"}, 512'(busy_o), 512'(1));
            if (coe_rd_ena_o) begin
                got_addr.push_back(coe_rd_addr_o);
                got_sel.push_back(coe_rd_sel_o);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            prev_ena   = coe_rd_ena_o;
            prev_addr  = coe_rd_addr_o;
            prev_stall = cg_valid_o && !cg_ready_i;
            prev_out   = cur_out;
            if (cg_valid_o && cg_ready_i) begin
                got_cg.push_back(cur_out);
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (got_cg.size() == reset_after) fin = 1'b1;
            end
            if (done_o) begin
                done_cyc = cyc;
                fin      = 1'b1;
                check_output({tag, "_busy_after_done"}, 512'(busy_o), 512'(0));
            end
            if (!fin) begin
                @(posedge clk);
                #1;
                cyc++;
                start_i = (cyc == busy_start_cyc);
                if (start_i) begin
                    tu_size_i = TU_SIZE_4X4;
                    tu_sel_i  = COMP_V;
                    tu_base_i = 9'h1FF;
                end
                coe_rd_dat_i = prev_ena ? mem[prev_addr] : rand_cg();
                if (toggle_ready) cg_ready_i = ~cg_ready_i;
            end
        end
        start_i = 1'b0;
        check_output({tag, "_completed"}, 512'(fin), 512'(1));
    endtask

    task automatic compare_tu(input string tag, input logic [1:0] sel, input bit full);
        if (full) begin
            check_output({tag, "_nreads"}, 512'(got_addr.size()), 512'(exp_addr.size()));
            check_output({tag, "_ncg"},    512'(got_cg.size()),   512'(exp_cg.size()));
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), 512'(got_addr[i]), 512'(exp_addr[i]));
            check_output($sformatf("%s_sel%0d", tag, i),  512'(got_sel[i]),  512'(sel));
        end
        for (int i = 0; i < got_cg.size() && i < exp_cg.size(); i++)
            check_output($sformatf("%s_cg%0d", tag, i), 512'(got_cg[i]), 512'(exp_cg[i]));
    endtask

    initial begin
        int            lit [16];
        logic [DW-1:0] lit_vec;
        logic [8:0]    addr16 [10];
        lit    = '{1, 5, 2, 9, 6, 3, 13, 10, 7, 4, 14, 11, 8, 15, 12, 16};
        addr16 = '{9'h040, 9'h042, 9'h041, 9'h048, 9'h043, 9'h044, 9'h04A, 9'h049, 9'h046, 9'h045};
        rst_n        = 1'b0;
        start_i      = 1'b0;
        tu_size_i    = '0;
        tu_sel_i     = '0;
        tu_base_i    = '0;
        cg_ready_i   = 1'b0;
        coe_rd_dat_i = '0;
        for (int a = 0; a < 512; a++) mem[a] = rand_cg();

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;

        $display("[TB] 4x4 Y TU, raster k+1 data");
        for (int k = 0; k < 16; k++) mem[0][(16-k)*COEFF_WIDTH-1 -: COEFF_WIDTH] = COEFF_WIDTH'(k + 1);
        lit_vec = '0;
        for (int n = 0; n < 16; n++) lit_vec[(16-n)*COEFF_WIDTH-1 -: COEFF_WIDTH] = COEFF_WIDTH'(lit[n]);
        build_expected(TU_SIZE_4X4, 9'h000);
        run_tu("t4", TU_SIZE_4X4, COMP_Y, 9'h000, 1'b0, -1, -1);
        compare_tu("t4", COMP_Y, 1'b1);
        check_output("t4_first_read_cyc",  512'(first_rd_cyc),  512'(1));
        check_output("t4_first_valid_cyc", 512'(first_vld_cyc), 512'(3));
        check_output("t4_done_cyc",        512'(done_cyc),      512'(4));
        if (got_cg.size() > 0) begin
            check_output("t4_scan_literal", 512'(got_cg[0].dat),  512'(lit_vec));
            check_output("t4_sig_all",      512'(got_cg[0].sig),  512'(16'hFFFF));
            check_output("t4_last",         512'(got_cg[0].last), 512'(1));
        end

        $display("[TB] 16x16 U TU at 0x040 with a start pulse while busy");
        build_expected(TU_SIZE_16X16, 9'h040);
        run_tu("t16", TU_SIZE_16X16, COMP_U, 9'h040, 1'b0, -1, 5);
        compare_tu("t16", COMP_U, 1'b1);
        for (int i = 0; i < 10 && i < got_addr.size(); i++)
            check_output($sformatf("t16_addr_literal%0d", i), 512'(got_addr[i]), 512'(addr16[i]));

        $display("[TB] 32x32 V TU with toggling ready");
        build_expected(TU_SIZE_32X32, 9'h000);
        run_tu("t32", TU_SIZE_32X32, COMP_V, 9'h000, 1'b1, -1, -1);
        compare_tu("t32", COMP_V, 1'b1);

        $display("[TB] reset at the 10th CG of a 32x32 TU");
        build_expected(TU_SIZE_32X32, 9'h000);
        run_tu("trst", TU_SIZE_32X32, COMP_Y, 9'h000, 1'b0, 10, -1);
        compare_tu("trst", COMP_Y, 1'b0);
        check_output("trst_ncg_before_reset", 512'(got_cg.size()), 512'(10));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("trst");
        rst_n = 1'b1;
        build_expected(TU_SIZE_4X4, 9'h000);
        run_tu("tpost", TU_SIZE_4X4, COMP_Y, 9'h000, 1'b0, -1, -1);
        compare_tu("tpost", COMP_Y, 1'b1);
        check_output("tpost_done_cyc", 512'(done_cyc), 512'(4));

        $display("[TB] 8x8 TU where only CG0 is nonzero");
        mem[9'h100] = rand_cg();
        mem[9'h101] = '0;
        mem[9'h102] = '0;
        mem[9'h103] = '0;
        build_expected(TU_SIZE_8X8, 9'h100);
        run_tu("tz", TU_SIZE_8X8, COMP_Y, 9'h100, 1'b0, -1, -1);
        compare_tu("tz", COMP_Y, 1'b1);
`ifdef CABAC_CG_ZERO_SKIP_EN
        check_output("tz_presented", 512'(got_cg.size()), 512'(2));
        if (got_cg.size() == 2) begin
            check_output("tz_second_idx",  512'(got_cg[1].idx),  512'(3));
            check_output("tz_second_last", 512'(got_cg[1].last), 512'(1));
        end
`else
        check_output("tz_presented", 512'(got_cg.size()), 512'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
